wb_stage: RTL and testbench

Write-back stage: the pipeline's single writer of the general-purpose register file. It captures retiring instructions from the MEM stage and waits for late load data, asserting a stall while it waits. It sign- or zero-extends sub-word loads and drives exactly one register-file write per retiring instruction. Optionally it presents the in-flight write value on a forwarding port for the decode stage.

---
 rtl/wb_stage_pkg.sv | 27 ++
 rtl/wb_stage_if.sv | 33 +++
 rtl/wb_stage_load_ext.sv | 37 +++
 rtl/wb_stage.sv | 110 +++++++++++
 tb/tb_wb_stage.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared definitions for the write-back stage.
//   DataBus / DecodeRegBus : data and register-address widths
//   DataInit               : reset value for data registers
//   LT_*                   : load-type codes carried on in_ltype
//   WB_*                   : write-back FSM state encodings
// Optional feature macro used by this slice: WB_BYPASS_EN (see wb_stage.sv).
package wb_stage_pkg;

    localparam int DataBus      = 32;
    localparam int DecodeRegBus = 5;

    typedef logic [DataBus-1:0]      data_t;
    typedef logic [DecodeRegBus-1:0] reg_t;

    localparam data_t DataInit = '0;

    localparam logic [2:0] LT_LW  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    localparam logic [1:0] WB_IDLE  = 2'd0;
    localparam logic [1:0] WB_WAIT  = 2'd1;
    localparam logic [1:0] WB_VALID = 2'd2;

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM -> WB retiring-instruction handshake.
//   in_valid    MEM presents a retiring instruction
//   in_ready    WB can accept (transfer on in_valid && in_ready at clk edge)
//   in_wen      instruction writes a register
//   in_rw       destination register
//   in_result   ALU/link result for non-loads
//   in_load     instruction is a load (data follows on mem_rdata)
//   in_ltype    load type code (LT_*)
//   in_addr_lo  low two bits of the load address
// Modports: master = MEM stage side, slave = write-back stage side.
interface wb_stage_if;
    import wb_stage_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic       in_wen;
    reg_t       in_rw;
    data_t      in_result;
    logic       in_load;
    logic [2:0] in_ltype;
    logic [1:0] in_addr_lo;

    modport master (
        output in_valid, in_wen, in_rw, in_result, in_load, in_ltype, in_addr_lo,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_wen, in_rw, in_result, in_load, in_ltype, in_addr_lo,
        output in_ready
    );

endinterface

// File: rtl/wb_stage_load_ext.sv
// load_ext: combinational sub-word selection and sign/zero extension.
//   ltype    in  3   load type code (LT_*); unknown codes behave as lw
//   addr_lo  in  2   low address bits selecting the half/byte
//   rdata    in  32  raw load word
//   ext      out 32  extended result
module load_ext
    import wb_stage_pkg::*;
(
    input  logic [2:0] ltype,
    input  logic [1:0] addr_lo,
    input  data_t      rdata,
    output data_t      ext
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase

        case (ltype)
            LT_LH:   ext = {{16{half[15]}}, half};
            LT_LHU:  ext = {16'h0000, half};
            LT_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU:  ext = {24'h000000, byte_sel};
            default: ext = rdata;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage, the single writer of the register file.
// Captures retiring instructions, waits for late load data (stalling
// upstream meanwhile), extends sub-word loads and issues one register-file
// write per retiring instruction.
//   clk, reset           clock, async active-high reset
//   up (wb_stage_if)     MEM -> WB handshake (slave side)
//   mem_rvalid/rdata     late load data
//   rf_we/rf_rw/rf_rd    register-file write port
//   stall_req            freeze upstream while a load is pending
//   fwd_valid/rw/data    forwarding port for decode
// Macro WB_BYPASS_EN: when defined, the forwarding port mirrors the pending
// register-file write; otherwise it is tied to zero.
//
// state    | meaning
// ---------+------------------------------------
// WB_IDLE  | empty
// WB_WAIT  | load accepted, data outstanding
// WB_VALID | write presented, retires next edge
module wb_stage
    import wb_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    wb_stage_if.slave   up,
    input  logic        mem_rvalid,
    input  data_t       mem_rdata,
    output logic        rf_we,
    output reg_t        rf_rw,
    output data_t       rf_rd,
    output logic        stall_req,
    output logic        fwd_valid,
    output reg_t        fwd_rw,
    output data_t       fwd_data
);

    logic [1:0] state;
    logic       wen_q;
    reg_t       rw_q;
    data_t      result_q;
    logic [2:0] ltype_q;
    logic [1:0] addr_lo_q;
    data_t      ext_data;
    logic       accept;

    load_ext u_load_ext (
        .ltype   (ltype_q),
        .addr_lo (addr_lo_q),
        .rdata   (mem_rdata),
        .ext     (ext_data)
    );

    assign up.in_ready = (state != WB_WAIT);
    assign stall_req   = (state == WB_WAIT);
    assign accept      = up.in_valid && up.in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= WB_IDLE;
            wen_q     <= 1'b0;
            rw_q      <= '0;
            result_q  <= DataInit;
            ltype_q   <= LT_LW;
            addr_lo_q <= 2'b00;
        end else begin
            case (state)
                WB_WAIT: begin
                    if (mem_rvalid) begin
                        result_q <= ext_data;
                        state    <= WB_VALID;
                    end
                end
                WB_IDLE, WB_VALID: begin
                    // A VALID instruction retires on this edge; a new accept
                    // on the same edge refills the stage without a bubble.
                    if (accept) begin
                        wen_q <= up.in_wen;
                        rw_q  <= up.in_rw;
                        if (up.in_load) begin
                            ltype_q   <= up.in_ltype;
                            addr_lo_q <= up.in_addr_lo;
                            state     <= WB_WAIT;
                        end else begin
                            result_q <= up.in_result;
                            state    <= WB_VALID;
                        end
                    end else begin
                        state <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    // Outputs are gated by state so nothing leaks out outside VALID.
    assign rf_we = (state == WB_VALID) && wen_q && (rw_q != '0);
    assign rf_rw = (state == WB_VALID) ? rw_q : '0;
    assign rf_rd = (state == WB_VALID) ? result_q : DataInit;

`ifdef WB_BYPASS_EN
    assign fwd_valid = rf_we;
    assign fwd_rw    = rf_rw;
    assign fwd_data  = rf_rd;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rw    = '0;
    assign fwd_data  = DataInit;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic  clk = 1'b0;
    logic  reset = 1'b1;
    logic  mem_rvalid = 1'b0;
    data_t mem_rdata = '0;
    logic  rf_we, stall_req, fwd_valid;
    reg_t  rf_rw, fwd_rw;
    data_t rf_rd, fwd_data;

    wb_stage_if bus ();

    wb_stage dut (
        .clk        (clk),
        .reset      (reset),
        .up         (bus),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rf_we      (rf_we),
        .rf_rw      (rf_rw),
        .rf_rd      (rf_rd),
        .stall_req  (stall_req),
        .fwd_valid  (fwd_valid),
        .fwd_rw     (fwd_rw),
        .fwd_data   (fwd_data)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [36:0] exp_q[$];   // {rw, rd}

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    // Scoreboard monitor: every write pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rf_we) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_rw", {27'd0, rf_rw}, 32'hFFFF_FFFF);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("wr_rw", {27'd0, rf_rw}, {27'd0, e[36:32]});
                chk("wr_rd", rf_rd, e[31:0]);
            end
`ifdef WB_BYPASS_EN
            chk("fwd_valid", {31'd0, fwd_valid}, 32'd1);
            chk("fwd_rw", {27'd0, fwd_rw}, {27'd0, rf_rw});
            chk("fwd_data", fwd_data, rf_rd);
`else
            chk("fwd_valid_off", {31'd0, fwd_valid}, 32'd0);
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Presents one instruction; returns #1 after the accepting edge.
    task automatic issue(input logic wen, input reg_t rw, input data_t res,
                         input logic load, input logic [2:0] lt, input logic [1:0] alo,
                         input logic exp_we, input data_t exp_rd);
        int n = 0;
        bus.in_valid   = 1'b1;
        bus.in_wen     = wen;
        bus.in_rw      = rw;
        bus.in_result  = res;
        bus.in_load    = load;
        bus.in_ltype   = lt;
        bus.in_addr_lo = alo;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("in_ready_at_issue", {31'd0, bus.in_ready}, 32'd1);
        if (exp_we) exp_q.push_back({rw, exp_rd});
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_wen = 1'b0; bus.in_rw = '0; bus.in_result = '0;
        bus.in_load = 1'b0; bus.in_ltype = '0; bus.in_addr_lo = '0;
        #2;
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_rf_rw", {27'd0, rf_rw}, 32'd0);
        chk("rst_rf_rd", rf_rd, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("rst_fwd_rw", {27'd0, fwd_rw}, 32'd0);
        chk("rst_fwd_data", fwd_data, 32'd0);
        cycle(); cycle();
        reset = 1'b0;
        cycle();

        // Reset mid-WAIT: pending load dropped, no write ever issued.
        issue(1'b1, 5'd7, 32'h0, 1'b1, LT_LW, 2'd0, 1'b0, 32'h0);
        chk("wait_stall", {31'd0, stall_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstwait_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rstwait_stall", {31'd0, stall_req}, 32'd0);
        chk("rstwait_rf_we", {31'd0, rf_we}, 32'd0);
        cycle();
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;   // ignored in IDLE
        cycle();
        mem_rvalid = 1'b0;
        cycle();

        // Non-load: exactly one write cycle.
        issue(1'b1, 5'd5, 32'h1234_5678, 1'b0, LT_LW, 2'd0, 1'b1, 32'h1234_5678);
        chk("nl_we_n1", {31'd0, rf_we}, 32'd1);
        cycle();
        chk("nl_we_n2", {31'd0, rf_we}, 32'd0);

        // lb sign extension after 3 stall cycles.
        issue(1'b1, 5'd9, 32'h0, 1'b1, LT_LB, 2'd2, 1'b1, 32'hFFFF_FF80);
        chk("lb_stall1", {31'd0, stall_req}, 32'd1);
        chk("lb_ready1", {31'd0, bus.in_ready}, 32'd0);
        cycle();
        chk("lb_stall2", {31'd0, stall_req}, 32'd1);
        cycle();
        chk("lb_stall3", {31'd0, stall_req}, 32'd1);
        mem_rvalid = 1'b1; mem_rdata = 32'h0080_0000;
        cycle();
        mem_rvalid = 1'b0;
        chk("lb_stall_off", {31'd0, stall_req}, 32'd0);
        chk("lb_we", {31'd0, rf_we}, 32'd1);
        cycle();

        // lhu zero extension, data in first WAIT cycle.
        issue(1'b1, 5'd12, 32'h0, 1'b1, LT_LHU, 2'd2, 1'b1, 32'h0000_BEEF);
        mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000;
        cycle();
        mem_rvalid = 1'b0;
        chk("lhu_we", {31'd0, rf_we}, 32'd1);
        cycle();

        // lh sign extension of the lower half, and lbu of byte 3.
        issue(1'b1, 5'd13, 32'h0, 1'b1, LT_LH, 2'd0, 1'b1, 32'hFFFF_8001);
        mem_rvalid = 1'b1; mem_rdata = 32'h7FFF_8001;
        cycle();
        mem_rvalid = 1'b0;
        issue(1'b1, 5'd14, 32'h0, 1'b1, LT_LBU, 2'd3, 1'b1, 32'h0000_00A5);
        mem_rvalid = 1'b1; mem_rdata = 32'hA5FF_FFFF;
        cycle();
        mem_rvalid = 1'b0;
        cycle();

        // r0 destination: no write, next instruction accepted straight away.
        issue(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, LT_LW, 2'd0, 1'b0, 32'h0);
        chk("r0_we", {31'd0, rf_we}, 32'd0);
        issue(1'b1, 5'd3, 32'h0000_0033, 1'b0, LT_LW, 2'd0, 1'b1, 32'h0000_0033);
        chk("after_r0_we", {31'd0, rf_we}, 32'd1);
        cycle();

        // Back-to-back non-loads: one retire per cycle.
        issue(1'b1, 5'd10, 32'hAAAA_0001, 1'b0, LT_LW, 2'd0, 1'b1, 32'hAAAA_0001);
        bus.in_valid = 1'b1;
        chk("b2b_we1", {31'd0, rf_we}, 32'd1);
        issue(1'b1, 5'd11, 32'hBBBB_0002, 1'b0, LT_LW, 2'd0, 1'b1, 32'hBBBB_0002);
        bus.in_valid = 1'b1;
        chk("b2b_we2", {31'd0, rf_we}, 32'd1);
        issue(1'b1, 5'd12, 32'hCCCC_0003, 1'b0, LT_LW, 2'd0, 1'b1, 32'hCCCC_0003);
        chk("b2b_we3", {31'd0, rf_we}, 32'd1);
        cycle();
        chk("b2b_we_end", {31'd0, rf_we}, 32'd0);
        cycle(); cycle();

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
